vga_plot_arbiter: RTL and testbench

Shares the single pixel-write port of the 160x120 `vga_adapter` (`plot`/`x`/`y`/`colour`) among up to `NREQ` pixel sources, such as `init_screen`, `game_plot` and a score overlay. It replaces hand-muxing of the VGA inputs by top-level state. Each source keeps its existing `plot`/`waitrequest` handshake. The arbiter grants one pixel per cycle using round-robin, supports an exclusive lock for multi-pixel operations such as a full-screen clear, and registers the pixel toward the adapter.

---
 rtl/vga_plot_arbiter.sv | 175 +++++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the single pixel-write port of the 160x120 VGA
// adapter among NREQ pixel sources. It grants one pixel per cycle in
// round-robin order and offers an exclusive lock for multi-pixel operations.
// The granted pixel is registered toward the adapter.
module vga_plot_arbiter #(
    parameter int NREQ  = 3,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_plot,
    input  logic [NREQ*8-1:0]   req_x,
    input  logic [NREQ*7-1:0]   req_y,
    input  logic [NREQ*3-1:0]   req_colour,
    input  logic [NREQ-1:0]     req_lock,
    input  logic [NREQ-1:0]     req_enable,
    input  logic                clr_count,
    output logic [NREQ-1:0]     req_waitrequest,
    output logic                vga_plot,
    output logic [7:0]          vga_x,
    output logic [6:0]          vga_y,
    output logic [2:0]          vga_colour,
    output logic [2:0]          grant_id,
    output logic                locked,
    output logic [CNT_W-1:0]    pixel_count
);

    typedef enum logic {ST_IDLE, ST_OWNED} lockState_t;

    lockState_t      r_state;
    lockState_t      w_nextState;
    logic [2:0]      r_owner;
    logic [2:0]      w_nextOwner;
    logic [2:0]      r_lastGrant;

    logic            w_ownerHeld;
    logic [NREQ-1:0] w_elig;
    logic            w_grantValid;
    logic [2:0]      w_grantIdx;
    logic            w_foundAbove;
    logic [2:0]      w_idxAbove;
    logic            w_foundAny;
    logic [2:0]      w_idxAny;
    logic [7:0]      w_selX;
    logic [6:0]      w_selY;
    logic [2:0]      w_selColour;
    logic            w_selLock;

    // The lock survives this cycle only if the owner still asks for it and is
    // still enabled. This check comes before selection, so a released lock
    // lets the other requesters compete in the same cycle.
    always_comb begin
        w_ownerHeld = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_state == ST_OWNED && i[2:0] == r_owner && req_lock[i] && req_enable[i])
                w_ownerHeld = 1'b1;
        end
    end

    // A requester is eligible when it plots, is enabled, and either no lock is
    // held or it is the owner. Nothing is eligible while reset is asserted.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_elig[i] = req_plot[i] & req_enable[i] & ~rst
                        & (~w_ownerHeld | (i[2:0] == r_owner));
        end
    end

    // Round-robin pick. The first choice is the lowest eligible index above
    // the last grant. If there is none, the pick wraps to the lowest eligible
    // index overall.
    always_comb begin
        w_foundAbove = 1'b0;
        w_idxAbove   = '0;
        w_foundAny   = 1'b0;
        w_idxAny     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_foundAny = 1'b1;
                w_idxAny   = i[2:0];
                if (i > int'(r_lastGrant)) begin
                    w_foundAbove = 1'b1;
                    w_idxAbove   = i[2:0];
                end
            end
        end
        w_grantValid = w_foundAbove | w_foundAny;
        w_grantIdx   = w_foundAbove ? w_idxAbove : w_idxAny;
    end

    // Select the granted requester's pixel data and lock request.
    always_comb begin
        w_selX      = '0;
        w_selY      = '0;
        w_selColour = '0;
        w_selLock   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (i[2:0] == w_grantIdx) begin
                w_selX      = req_x[i*8 +: 8];
                w_selY      = req_y[i*7 +: 7];
                w_selColour = req_colour[i*3 +: 3];
                w_selLock   = req_lock[i];
            end
        end
    end

    // Lock state register. Reset drops any held lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
        end else begin
            r_state <= w_nextState;
            r_owner <= w_nextOwner;
        end
    end

    // Next lock state. Ownership is kept while it holds. Otherwise a grant that
    // carries a lock request takes ownership for the granted requester.
    always_comb begin
        w_nextState = ST_IDLE;
        w_nextOwner = r_owner;
        if (w_ownerHeld) begin
            w_nextState = ST_OWNED;
        end else if (w_grantValid && w_selLock) begin
            w_nextState = ST_OWNED;
            w_nextOwner = w_grantIdx;
        end
    end

    // Outputs from the lock state and the grant. Only the granted requester
    // sees waitrequest low.
    always_comb begin
        locked = (r_state == ST_OWNED);
        for (int i = 0; i < NREQ; i++) begin
            req_waitrequest[i] = ~(w_grantValid && (i[2:0] == w_grantIdx));
        end
    end

    // Register the accepted pixel toward the adapter. Without a grant, plot
    // drops low and the data and grant id hold their values.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_plot    <= 1'b0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            grant_id    <= '0;
            r_lastGrant <= 3'(NREQ - 1);
        end else if (w_grantValid) begin
            vga_plot    <= 1'b1;
            vga_x       <= w_selX;
            vga_y       <= w_selY;
            vga_colour  <= w_selColour;
            grant_id    <= w_grantIdx;
            r_lastGrant <= w_grantIdx;
        end else begin
            vga_plot    <= 1'b0;
        end
    end

    // Count accepted pixels. A clear that coincides with an accept counts
    // that pixel, so the count becomes 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_count <= '0;
        end else if (clr_count) begin
            pixel_count <= w_grantValid ? CNT_W'(1) : '0;
        end else if (w_grantValid) begin
            pixel_count <= pixel_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed testbench for vga_plot_arbiter with three requesters and a 4-bit
// pixel counter, so the counter wrap can be reached in a few cycles.
module tb_vga_plot_arbiter;

   logic        clk;
   logic        rst;
   logic [2:0]  req_plot;
   logic [23:0] req_x;
   logic [20:0] req_y;
   logic [8:0]  req_colour;
   logic [2:0]  req_lock;
   logic [2:0]  req_enable;
   logic        clr_count;
   logic [2:0]  req_waitrequest;
   logic        vga_plot;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  vga_colour;
   logic [2:0]  grant_id;
   logic        locked;
   logic [3:0]  pixel_count;

   int vectors;
   int miscompares;

   vga_plot_arbiter #(.NREQ(3), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .req_plot(req_plot), .req_x(req_x), .req_y(req_y),
      .req_colour(req_colour), .req_lock(req_lock), .req_enable(req_enable),
      .clr_count(clr_count), .req_waitrequest(req_waitrequest), .vga_plot(vga_plot),
      .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .grant_id(grant_id),
      .locked(locked), .pixel_count(pixel_count)
   );

   // 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge. Waitrequest is sampled 1 ns later.
   // Registered outputs are sampled 1 ns after the rising edge.
   task automatic doReset();
      @(negedge clk);
      rst = 1'b1; req_plot = 3'b000; req_lock = 3'b000; req_enable = 3'b111; clr_count = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      req_x = {8'd22, 8'd21, 8'd20};
      req_y = {7'd2, 7'd1, 7'd0};
      req_colour = {3'd6, 3'd5, 3'd4};
      @(negedge clk);
      rst = 1'b1; req_plot = 3'b111; req_enable = 3'b111; req_lock = 3'b000; clr_count = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         vectors++;
         if (req_waitrequest !== 3'b111) begin
            miscompares++;
            $display("[TB] FAIL reset_wait c=%0d got %b want 111", c, req_waitrequest);
         end
         @(posedge clk); #1;
         vectors++;
         if ({vga_plot, vga_x, vga_y, vga_colour, grant_id, locked, pixel_count} !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_outs c=%0d got plot=%b x=%0d y=%0d col=%0d gid=%0d lk=%b cnt=%0d want all 0",
                     c, vga_plot, vga_x, vga_y, vga_colour, grant_id, locked, pixel_count);
         end
         @(negedge clk);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (req_waitrequest !== 3'b110) begin
         miscompares++;
         $display("[TB] FAIL reset_first_wait got %b want 110", req_waitrequest);
      end
      @(posedge clk); #1;
      vectors++;
      if (vga_plot !== 1'b1 || grant_id !== 3'd0 || vga_x !== 8'd20 || vga_colour !== 3'd4) begin
         miscompares++;
         $display("[TB] FAIL reset_first_out got plot=%b gid=%0d x=%0d col=%0d want 1 0 20 4",
                  vga_plot, grant_id, vga_x, vga_colour);
      end
   endtask

   task automatic test_single_source();
      doReset();
      req_plot = 3'b010;
      req_y = {7'd0, 7'd5, 7'd0};
      req_colour = {3'd0, 3'd3, 3'd0};
      for (int k = 0; k < 4; k++) begin
         req_x = {8'd0, 8'(10 + k), 8'd0};
         #1;
         vectors++;
         if (req_waitrequest !== 3'b101) begin
            miscompares++;
            $display("[TB] FAIL single_wait k=%0d got %b want 101", k, req_waitrequest);
         end
         @(posedge clk); #1;
         vectors++;
         if (vga_plot !== 1'b1 || vga_x !== 8'(10 + k) || vga_y !== 7'd5 || vga_colour !== 3'd3 || grant_id !== 3'd1) begin
            miscompares++;
            $display("[TB] FAIL single_out k=%0d got plot=%b x=%0d y=%0d col=%0d gid=%0d want 1 %0d 5 3 1",
                     k, vga_plot, vga_x, vga_y, vga_colour, grant_id, 10 + k);
         end
         @(negedge clk);
      end
      req_plot = 3'b000;
      @(posedge clk); #1;
      vectors++;
      if (vga_plot !== 1'b0 || pixel_count !== 4'd4 || vga_x !== 8'd13 || grant_id !== 3'd1) begin
         miscompares++;
         $display("[TB] FAIL single_idle got plot=%b cnt=%0d x=%0d gid=%0d want 0 4 13 1",
                  vga_plot, pixel_count, vga_x, grant_id);
      end
   endtask

   task automatic test_round_robin();
      doReset();
      req_plot = 3'b111;
      for (int k = 0; k < 6; k++) begin
         logic [2:0] expId;
         logic [2:0] expWait;
         expId = 3'(k % 3);
         expWait = ~(3'b001 << expId);
         #1;
         vectors++;
         if (req_waitrequest !== expWait) begin
            miscompares++;
            $display("[TB] FAIL rr_wait k=%0d got %b want %b", k, req_waitrequest, expWait);
         end
         @(posedge clk); #1;
         vectors++;
         if (grant_id !== expId || vga_plot !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL rr_grant k=%0d got gid=%0d plot=%b want %0d 1", k, grant_id, vga_plot, expId);
         end
         @(negedge clk);
      end
      req_plot = 3'b000;
   endtask

   task automatic test_lock();
      doReset();
      req_plot = 3'b101; req_lock = 3'b001;
      #1;
      vectors++;
      if (req_waitrequest !== 3'b110) begin
         miscompares++;
         $display("[TB] FAIL lock_take_wait got %b want 110", req_waitrequest);
      end
      @(posedge clk); #1;
      vectors++;
      if (locked !== 1'b1 || grant_id !== 3'd0) begin
         miscompares++;
         $display("[TB] FAIL lock_take got lk=%b gid=%0d want 1 0", locked, grant_id);
      end
      @(negedge clk);
      req_plot = 3'b100;
      for (int c = 0; c < 3; c++) begin
         #1;
         vectors++;
         if (req_waitrequest !== 3'b111) begin
            miscompares++;
            $display("[TB] FAIL lock_idle_wait c=%0d got %b want 111", c, req_waitrequest);
         end
         @(posedge clk); #1;
         vectors++;
         if (locked !== 1'b1 || vga_plot !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL lock_idle c=%0d got lk=%b plot=%b want 1 0", c, locked, vga_plot);
         end
         @(negedge clk);
      end
      req_lock = 3'b000;
      #1;
      vectors++;
      if (req_waitrequest !== 3'b011) begin
         miscompares++;
         $display("[TB] FAIL lock_release_wait got %b want 011", req_waitrequest);
      end
      @(posedge clk); #1;
      vectors++;
      if (locked !== 1'b0 || grant_id !== 3'd2 || vga_plot !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL lock_release got lk=%b gid=%0d plot=%b want 0 2 1", locked, grant_id, vga_plot);
      end
      @(negedge clk);
      req_plot = 3'b000;
   endtask

   task automatic test_mask_release();
      doReset();
      req_plot = 3'b010; req_lock = 3'b010;
      #1;
      vectors++;
      if (req_waitrequest !== 3'b101) begin
         miscompares++;
         $display("[TB] FAIL mask_take_wait got %b want 101", req_waitrequest);
      end
      @(posedge clk); #1;
      vectors++;
      if (locked !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL mask_take got lk=%b want 1", locked);
      end
      @(negedge clk);
      req_plot = 3'b011;
      #1;
      vectors++;
      if (req_waitrequest !== 3'b101) begin
         miscompares++;
         $display("[TB] FAIL mask_owned_wait got %b want 101", req_waitrequest);
      end
      @(negedge clk);
      req_enable = 3'b101;
      for (int c = 0; c < 3; c++) begin
         #1;
         vectors++;
         if (req_waitrequest !== 3'b110) begin
            miscompares++;
            $display("[TB] FAIL mask_wait c=%0d got %b want 110", c, req_waitrequest);
         end
         @(posedge clk); #1;
         vectors++;
         if (locked !== 1'b0 || grant_id !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL mask_out c=%0d got lk=%b gid=%0d want 0 0", c, locked, grant_id);
         end
         @(negedge clk);
      end
      req_plot = 3'b000; req_lock = 3'b000; req_enable = 3'b111;
   endtask

   task automatic test_reset_mid_lock();
      doReset();
      req_plot = 3'b001; req_lock = 3'b001;
      req_x = {8'd0, 8'd0, 8'd77};
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      vectors++;
      if (req_waitrequest !== 3'b111) begin
         miscompares++;
         $display("[TB] FAIL midrst_wait got %b want 111", req_waitrequest);
      end
      @(posedge clk); #1;
      vectors++;
      if (locked !== 1'b0 || vga_plot !== 1'b0 || vga_x !== 8'd0 || pixel_count !== 4'd0) begin
         miscompares++;
         $display("[TB] FAIL midrst_outs got lk=%b plot=%b x=%0d cnt=%0d want 0 0 0 0",
                  locked, vga_plot, vga_x, pixel_count);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      vectors++;
      if (req_waitrequest !== 3'b110) begin
         miscompares++;
         $display("[TB] FAIL midrst_again_wait got %b want 110", req_waitrequest);
      end
      @(posedge clk); #1;
      vectors++;
      if (vga_plot !== 1'b1 || vga_x !== 8'd77 || locked !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL midrst_again got plot=%b x=%0d lk=%b want 1 77 1", vga_plot, vga_x, locked);
      end
      @(negedge clk);
      req_plot = 3'b000; req_lock = 3'b000;
   endtask

   task automatic test_counter_wrap();
      doReset();
      req_plot = 3'b001;
      for (int k = 0; k < 16; k++) begin
         @(posedge clk); #1;
         vectors++;
         if (pixel_count !== 4'((k + 1) % 16)) begin
            miscompares++;
            $display("[TB] FAIL cnt_run k=%0d got %0d want %0d", k, pixel_count, (k + 1) % 16);
         end
         @(negedge clk);
      end
      clr_count = 1'b1;
      @(posedge clk); #1;
      vectors++;
      if (pixel_count !== 4'd1) begin
         miscompares++;
         $display("[TB] FAIL cnt_clr_accept got %0d want 1", pixel_count);
      end
      @(negedge clk);
      req_plot = 3'b000;
      @(posedge clk); #1;
      vectors++;
      if (pixel_count !== 4'd0) begin
         miscompares++;
         $display("[TB] FAIL cnt_clr_alone got %0d want 0", pixel_count);
      end
      @(negedge clk);
      clr_count = 1'b0;
   endtask

   // Run every scenario in sequence, then print the summary.
   initial begin
      vectors = 0;
      miscompares = 0;
      rst = 1'b1; req_plot = '0; req_x = '0; req_y = '0; req_colour = '0;
      req_lock = '0; req_enable = 3'b111; clr_count = 1'b0;
      test_reset();
      test_single_source();
      test_round_robin();
      test_lock();
      test_mask_release();
      test_reset_mid_lock();
      test_counter_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
